// File: rtl/riscv_pkg.sv
// riscv: shared RV32 pipeline types.
// Contents: the decode field types (opcode_t, funct3_t, funct7_t), the fetch
// address and word types (pc_t, inst_t), the fetch FSM state type, the
// default reset PC, and a PC increment helper.
package riscv;

    typedef logic [6:0]  opcode_t;
    typedef logic [2:0]  funct3_t;
    typedef logic [6:0]  funct7_t;

    typedef logic [31:0] pc_t;
    typedef logic [31:0] inst_t;

    typedef enum logic [1:0] {
        FETCH_BOOT = 2'd0,
        FETCH_RUN  = 2'd1,
        FETCH_HALT = 2'd2
    } fetch_state_t;

    localparam pc_t FETCH_RESET_PC = 32'h0000_0000;

    // Next sequential word address; wraps modulo 2^32.
    function automatic pc_t pc_inc(input pc_t pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small circular buffer of fetched {pc, inst} entries.
// Ports:
//   clk, resetn       clock, asynchronous active-low reset
//   flush_i           synchronous flush (wins over push/pop)
//   push_i, wdata_i   write an entry (accepted when not full, or full and popping)
//   pop_i             remove the head entry (ignored when empty)
//   rdata_o           head entry; all-zero after reset
//   empty_o, full_o   occupancy flags
//   count_o           number of stored entries
module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [63:0]   wdata_i,
    output logic [63:0]   rdata_o,
    output logic          empty_o,
    output logic          full_o,
    output logic [CW-1:0] count_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [63:0]   mem_q [DEPTH];
    logic [PW-1:0] rd_q;
    logic [PW-1:0] wr_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          pop_eff_s;
    logic          push_eff_s;

    // Pointer advance with explicit wrap so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PW'(1);
        end
    endfunction

    assign empty_o    = (cnt_q == '0);
    assign full_o     = (cnt_q == CW'(DEPTH));
    assign count_o    = cnt_q;
    assign rdata_o    = mem_q[rd_q];
    assign pop_eff_s  = pop_i & ~empty_o;
    // A full FIFO can still take a push in the cycle its head is popped.
    assign push_eff_s = push_i & (~full_o | pop_eff_s);

    // Occupancy next-state.
    always_comb begin
        cnt_d = cnt_q;
        case ({push_eff_s, pop_eff_s})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage, pointers and occupancy registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= 64'd0;
            end
        end else if (flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_eff_s) begin
                mem_q[wr_q] <= wdata_i;
                wr_q        <= ptr_inc(wr_q);
            end
            if (pop_eff_s) begin
                rd_q <= ptr_inc(rd_q);
            end
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fetch.sv
// fetch: RV32 instruction fetch stage.
// Holds the PC, issues in-order word requests to instruction memory, buffers
// responses in fetch_fifo and presents one instruction per cycle to decode.
// Redirects flush the buffer; responses still in flight are dropped through a
// discard counter. A misaligned redirect target parks the stage in HALT with
// fetch_err set until an aligned redirect arrives.
// Ports:
//   clk, resetn                      clock, asynchronous active-low reset
//   imem_req/imem_addr/imem_gnt      request handshake (held until granted)
//   imem_rvalid/imem_rdata           in-order responses, no backpressure
//   redirect/redirect_pc             taken branch/jump restart
//   stall                            decode not accepting; head is held
//   inst_valid/inst/inst_pc          head instruction and its PC
//   opcode/funct3/funct7             decode fields of inst
//   fetch_err                        sticky misaligned-redirect flag
// Build option: FETCH_BYPASS_EN -- an accepted response arriving while the
// buffer is empty is shown to decode in its own rvalid cycle.
module fetch
    import riscv::*;
#(
    parameter pc_t         RESET_PC = FETCH_RESET_PC,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output opcode_t     opcode,
    output funct3_t     funct3,
    output funct7_t     funct7,
    output logic        fetch_err
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    fetch_state_t  state_q,   state_d;
    pc_t           pc_q,      pc_d;       // address of the current/next request
    logic [CW-1:0] cnt_q,     cnt_d;      // granted, response not yet returned
    logic [CW-1:0] disc_q,    disc_d;     // responses still to be dropped
    logic          req_q,     req_d;
    logic          rpend_q,   rpend_d;    // redirect waiting on an old grant
    pc_t           rpc_q,     rpc_d;      // target of that pending redirect
    pc_t           resp_pc_q, resp_pc_d;  // PC of the next accepted response
    logic          err_q,     err_d;

    logic          gnt_acc_s;
    logic          aligned_s;
    logic          live_s;
    logic          fifo_push_s;
    logic          fifo_pop_s;
    logic          fifo_empty_s;
    logic          fifo_full_s;
    logic [CW-1:0] fifo_count_s;
    logic [CW-1:0] occ_d;
    logic [CW:0]   inflight_d;
    logic [63:0]   fifo_rdata_s;
    logic [63:0]   head_s;

    assign gnt_acc_s = req_q & imem_gnt;
    assign aligned_s = (redirect_pc[1:0] == 2'b00);
    // A response is kept only when nothing is owed to discard and no redirect
    // is flushing in the same cycle.
    assign live_s    = imem_rvalid & (disc_q == '0) & ~redirect;

`ifdef FETCH_BYPASS_EN
    logic byp_s;
    assign byp_s       = live_s & fifo_empty_s;
    // A bypassed word consumed by decode this cycle never enters the buffer.
    assign fifo_push_s = live_s & ~(byp_s & ~stall);
    assign fifo_pop_s  = ~fifo_empty_s & ~stall;
    assign inst_valid  = ~fifo_empty_s | byp_s;
    assign head_s      = byp_s ? {resp_pc_q, imem_rdata} : fifo_rdata_s;
`else
    assign fifo_push_s = live_s;
    assign fifo_pop_s  = ~fifo_empty_s & ~stall;
    assign inst_valid  = ~fifo_empty_s;
    assign head_s      = fifo_rdata_s;
`endif

    assign inst      = head_s[31:0];
    assign inst_pc   = head_s[63:32];
    assign opcode    = head_s[6:0];
    assign funct3    = head_s[14:12];
    assign funct7    = head_s[31:25];
    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign fetch_err = err_q;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .flush_i (redirect),
        .push_i  (fifo_push_s),
        .pop_i   (fifo_pop_s),
        .wdata_i ({resp_pc_q, imem_rdata}),
        .rdata_o (fifo_rdata_s),
        .empty_o (fifo_empty_s),
        .full_o  (fifo_full_s),
        .count_o (fifo_count_s)
    );

    // FSM, PC, outstanding/discard bookkeeping and redirect handling.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cnt_d     = cnt_q + CW'(gnt_acc_s) - CW'(imem_rvalid);
        disc_d    = disc_q;
        rpend_d   = rpend_q;
        rpc_d     = rpc_q;
        resp_pc_d = resp_pc_q;
        err_d     = err_q;

        case (state_q)
            FETCH_BOOT: state_d = FETCH_RUN;
            FETCH_RUN:  state_d = FETCH_RUN;
            FETCH_HALT: state_d = FETCH_HALT;
            default:    state_d = FETCH_BOOT;
        endcase

        if (redirect) begin
            state_d   = aligned_s ? FETCH_RUN : FETCH_HALT;
            err_d     = ~aligned_s;
            // Everything outstanding after this cycle belongs to the old stream.
            disc_d    = cnt_d;
            rpc_d     = redirect_pc;
            resp_pc_d = redirect_pc;
            if (req_q && !imem_gnt) begin
                // Finish the handshake at the old address first.
                rpend_d = 1'b1;
                pc_d    = pc_q;
            end else begin
                rpend_d = 1'b0;
                pc_d    = redirect_pc;
            end
        end else begin
            if (imem_rvalid && (disc_q != '0)) begin
                disc_d = disc_q - CW'(1);
            end else begin
                disc_d = disc_q;
            end
            if (gnt_acc_s) begin
                if (rpend_q) begin
                    // The late old-stream grant is owed a discard as well.
                    pc_d    = rpc_q;
                    rpend_d = 1'b0;
                    disc_d  = disc_d + CW'(1);
                end else begin
                    pc_d    = pc_inc(pc_q);
                    rpend_d = rpend_q;
                end
            end else begin
                pc_d = pc_q;
            end
            if (live_s) begin
                resp_pc_d = pc_inc(resp_pc_q);
            end else begin
                resp_pc_d = resp_pc_q;
            end
        end
    end

    // Request issue: keep a raised request stable until granted, otherwise
    // request only while every possible response has a buffer slot.
    always_comb begin
        if (redirect) begin
            occ_d = '0;
        end else begin
            occ_d = fifo_count_s + CW'(fifo_push_s) - CW'(fifo_pop_s);
        end
        inflight_d = {1'b0, cnt_d} + {1'b0, occ_d};
        if (req_q && !imem_gnt) begin
            req_d = 1'b1;
        end else if ((state_d == FETCH_RUN) && (inflight_d < (CW + 1)'(DEPTH))
                     && !(fifo_full_s && !fifo_pop_s && !redirect)) begin
            req_d = 1'b1;
        end else begin
            req_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= FETCH_BOOT;
            pc_q      <= RESET_PC;
            cnt_q     <= '0;
            disc_q    <= '0;
            req_q     <= 1'b0;
            rpend_q   <= 1'b0;
            rpc_q     <= RESET_PC;
            resp_pc_q <= RESET_PC;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            disc_q    <= disc_d;
            req_q     <= req_d;
            rpend_q   <= rpend_d;
            rpc_q     <= rpc_d;
            resp_pc_q <= resp_pc_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_fetch.sv
// tb_fetch: directed self-checking bench for the fetch stage.
module tb_fetch;
    import riscv::*;

`ifdef FETCH_BYPASS_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        stall = 1'b0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    opcode_t     opcode;
    funct3_t     funct3;
    funct7_t     funct7;
    logic        fetch_err;

    logic        gnt_en = 1'b1;
    logic        hold_resp = 1'b0;
    logic [31:0] pend_addr [$];

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;

    fetch dut (
        .clk         (clk),
        .resetn      (resetn),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7      (funct7),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_BE13;
    endfunction

    assign imem_gnt = gnt_en;

    // Memory model: in-order, one response per cycle, optionally held back.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            imem_rvalid <= 1'b0;
            imem_rdata  <= 32'h0;
            pend_addr.delete();
        end else begin
            if (imem_req && imem_gnt) pend_addr.push_back(imem_addr);
            if (!hold_resp && pend_addr.size() > 0) begin
                imem_rvalid <= 1'b1;
                imem_rdata  <= mem_word(pend_addr.pop_front());
            end else begin
                imem_rvalid <= 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Wait for the next valid head (popped at the following edge) and check it.
    task automatic get_inst(input string tag, input logic [31:0] exp_pc);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            if (inst_valid === 1'b1) begin
                got = 1'b1;
                chk({tag, "_pc"}, inst_pc, exp_pc);
                chk({tag, "_inst"}, inst, mem_word(exp_pc));
            end
            tick();
        end
        chk({tag, "_seen"}, {31'd0, got}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] snap_inst;
        logic [31:0] snap_pc;

        // Reset values.
        #12;
        chk("rst_req",   32'(imem_req),   32'd0);
        chk("rst_addr",  imem_addr,       32'h0000_0000);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst",  inst,            32'h0);
        chk("rst_pc",    inst_pc,         32'h0);
        chk("rst_err",   32'(fetch_err),  32'd0);

        // Boot: one idle cycle, then requests 0x0, 0x4...
        @(negedge clk);
        resetn = 1'b1;
        tick();
        chk("boot_req1",   32'(imem_req),   32'd1);
        chk("boot_addr1",  imem_addr,       32'h0);
        chk("boot_valid1", 32'(inst_valid), 32'd0);
        tick();
        chk("boot_addr2",  imem_addr,       32'h4);
        chk("boot_valid2", 32'(inst_valid), (LAT == 2) ? 32'd1 : 32'd0);
        if (LAT == 3) tick();
        chk("first_valid",  32'(inst_valid), 32'd1);
        chk("first_pc",     inst_pc,         32'h0);
        chk("first_inst",   inst,            32'hDEAD_BE13);
        chk("first_opcode", 32'(opcode),     32'h13);
        chk("first_funct3", 32'(funct3),     32'h3);
        chk("first_funct7", 32'(funct7),     32'h6F);
        get_inst("s0", 32'h0);
        get_inst("s1", 32'h4);
        get_inst("s2", 32'h8);

        // Stall with full buffer: outputs bit-stable, no requests.
        stall = 1'b1;
        repeat (4) tick();
        chk("stall_req",   32'(imem_req),   32'd0);
        chk("stall_valid", 32'(inst_valid), 32'd1);
        chk("stall_pc",    inst_pc,         32'hC);
        snap_inst = mem_word(32'hC);
        snap_pc   = 32'hC;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_inst",  inst,            snap_inst);
            chk("hold_pc",    inst_pc,         snap_pc);
            chk("hold_valid", 32'(inst_valid), 32'd1);
            chk("hold_req",   32'(imem_req),   32'd0);
        end
        stall = 1'b0;
        get_inst("st0", 32'hC);
        get_inst("st1", 32'h10);
        get_inst("st2", 32'h14);

        // Redirect with two responses outstanding.
        hold_resp = 1'b1;
        repeat (6) tick();
        chk("out2_req",   32'(imem_req),   32'd0);
        chk("out2_valid", 32'(inst_valid), 32'd0);
        redirect = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        chk("r1_valid_next", 32'(inst_valid), 32'd0);
        hold_resp = 1'b0;
        get_inst("r1a", 32'h100);
        get_inst("r1b", 32'h104);

        // Redirect while a request is pending ungranted.
        hold_resp = 1'b1;
        repeat (6) tick();
        gnt_en = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h180;
        tick();
        redirect = 1'b0;
        hold_resp = 1'b0;
        repeat (4) tick();
        chk("ung_req",   32'(imem_req), 32'd1);
        chk("ung_addr0", imem_addr,     32'h180);
        tick();
        chk("ung_addr1", imem_addr,     32'h180);
        redirect = 1'b1;
        redirect_pc = 32'h200;
        tick();
        redirect = 1'b0;
        chk("ung_addr2", imem_addr,     32'h180);
        chk("ung_req2",  32'(imem_req), 32'd1);
        gnt_en = 1'b1;
        tick();
        chk("ung_newaddr", imem_addr,     32'h200);
        chk("ung_newreq",  32'(imem_req), 32'd1);
        get_inst("r2a", 32'h200);
        get_inst("r2b", 32'h204);

        // Misaligned redirect: halt with fetch_err, then recover.
        redirect = 1'b1;
        redirect_pc = 32'h102;
        tick();
        redirect = 1'b0;
        chk("mis_err",   32'(fetch_err),  32'd1);
        chk("mis_valid", 32'(inst_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("halt_req",   32'(imem_req),   32'd0);
            chk("halt_err",   32'(fetch_err),  32'd1);
            chk("halt_valid", 32'(inst_valid), 32'd0);
            tick();
        end
        redirect = 1'b1;
        redirect_pc = 32'h300;
        tick();
        redirect = 1'b0;
        chk("rec_err", 32'(fetch_err), 32'd0);
        get_inst("r3a", 32'h300);
        get_inst("r3b", 32'h304);

        // PC wraps past the top of the address space.
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect = 1'b0;
        get_inst("wr0", 32'hFFFF_FFF8);
        get_inst("wr1", 32'hFFFF_FFFC);
        get_inst("wr2", 32'h0000_0000);

        // Asynchronous reset mid-burst.
        #2;
        resetn = 1'b0;
        #1;
        chk("ar_req",   32'(imem_req),   32'd0);
        chk("ar_addr",  imem_addr,       32'h0);
        chk("ar_valid", 32'(inst_valid), 32'd0);
        chk("ar_inst",  inst,            32'h0);
        chk("ar_pc",    inst_pc,         32'h0);
        chk("ar_err",   32'(fetch_err),  32'd0);
        @(negedge clk);
        resetn = 1'b1;
        tick();
        chk("ar_boot_req",  32'(imem_req), 32'd1);
        chk("ar_boot_addr", imem_addr,     32'h0);
        get_inst("ar0", 32'h0);
        get_inst("ar1", 32'h4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
